// File: rtl/gate_ctrl_list_sequencer_pkg.sv
// Shared types and constants for the gate control list sequencer.
// Covers the entry layout, the sequencer states and the list geometry.
package tsn_gcl_pkg;

  localparam int GCL_DEPTH = 8;
  localparam int GATE_W    = 8;
  localparam int INTV_W    = 16;
  localparam int IDX_W     = $clog2(GCL_DEPTH);
  localparam int NUM_W     = $clog2(GCL_DEPTH) + 1;
  localparam int ENTRY_W   = GATE_W + INTV_W;

  localparam logic [GATE_W-1:0] GATE_DEFAULT = 8'hFF;

  typedef struct packed {
    logic [GATE_W-1:0] gate;
    logic [INTV_W-1:0] interval;
  } gcl_entry_t;

  typedef enum logic [1:0] {
    ST_DISABLED   = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_RUN        = 2'd2,
    ST_HOLD       = 2'd3
  } gcl_state_e;

  // An entry count of 0 behaves like 1; counts above the table depth are clamped.
  function automatic logic [IDX_W-1:0] last_index(input logic [NUM_W-1:0] num);
    if (num == '0) return '0;
    if (num >= NUM_W'(GCL_DEPTH)) return IDX_W'(GCL_DEPTH - 1);
    return IDX_W'(num - NUM_W'(1));
  endfunction

endpackage

// File: rtl/gate_ctrl_list_sequencer_if.sv
// Configuration write bus for the gate control list table.
// Handshake: a write commits on the clock edge where i_gcl_wr is high; there is no backpressure.
interface gcl_cfg_if
  import tsn_gcl_pkg::*;
();
  logic               i_gcl_wr;
  logic [IDX_W-1:0]   iv_gcl_waddr;
  logic [ENTRY_W-1:0] iv_gcl_wdata;

  modport master (output i_gcl_wr, output iv_gcl_waddr, output iv_gcl_wdata);
  modport slave  (input  i_gcl_wr, input  iv_gcl_waddr, input  iv_gcl_wdata);
endinterface

// File: rtl/gate_ctrl_list_sequencer_gcl_entry_table.sv
// GCL register file with one synchronous write port and one combinational read port.
// A read of an address written in the same cycle returns the old content.
module gcl_entry_table
  import tsn_gcl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [IDX_W-1:0] iv_waddr,
  input  gcl_entry_t       iv_wdata,
  input  logic [IDX_W-1:0] iv_raddr,
  output gcl_entry_t       ov_rdata
);

  gcl_entry_t mem_q [GCL_DEPTH];
  gcl_entry_t mem_d [GCL_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (i_wr) mem_d[iv_waddr] = iv_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  assign ov_rdata = mem_q[iv_raddr];

endmodule

// File: rtl/gate_ctrl_list_sequencer.sv
// Walks the gate control list on each cycle start, holding every entry's gates for its interval,
// then keeps the last entry's gates until the next cycle start.
module gate_ctrl_list_sequencer
  import tsn_gcl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cycle_start,
  input  logic              i_gcl_enable,
  input  logic [NUM_W-1:0]  iv_gcl_entry_num,
  gcl_cfg_if.slave          cfg,
  output logic [GATE_W-1:0] ov_gate_state,
  output logic [IDX_W-1:0]  ov_slot_index,
  output logic              o_slot_change,
  output logic              o_cycle_overrun,
  output gcl_state_e        o_dbg_state
);

  gcl_state_e        state_q, state_d;
  logic [INTV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic              chg_q, chg_d;
  logic              ovr_q, ovr_d;
  logic              load;
  logic [IDX_W-1:0]  load_idx;
  gcl_entry_t        rd_entry;

  gcl_entry_table u_table (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr     (cfg.i_gcl_wr),
    .iv_waddr (cfg.iv_gcl_waddr),
    .iv_wdata (gcl_entry_t'(cfg.iv_gcl_wdata)),
    .iv_raddr (load_idx),
    .ov_rdata (rd_entry)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    last_d   = last_q;
    gate_d   = gate_q;
    chg_d    = 1'b0;
    ovr_d    = 1'b0;
    load     = 1'b0;
    load_idx = '0;
    case (state_q)
      ST_DISABLED: begin
        gate_d = GATE_DEFAULT;
        if (i_gcl_enable) state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        gate_d = GATE_DEFAULT;
        if (i_cycle_start) load = 1'b1;
      end
      ST_RUN: begin
        // A cycle start beats a simultaneous expiry; it is only an overrun if the list had time left.
        if (i_cycle_start) begin
          load  = 1'b1;
          ovr_d = !((idx_q == last_q) && (cnt_q == '0));
        end else if (cnt_q == '0) begin
          if (idx_q < last_q) begin
            load     = 1'b1;
            load_idx = idx_q + IDX_W'(1);
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q - INTV_W'(1);
        end
      end
      ST_HOLD: begin
        if (i_cycle_start) load = 1'b1;
      end
      default: state_d = ST_DISABLED;
    endcase

    if (load) begin
      state_d = ST_RUN;
      idx_d   = load_idx;
      gate_d  = rd_entry.gate;
      cnt_d   = (rd_entry.interval == '0) ? '0 : rd_entry.interval - INTV_W'(1);
      last_d  = last_index(iv_gcl_entry_num);
      chg_d   = 1'b1;
    end

    if (!i_gcl_enable) begin
      state_d = ST_DISABLED;
      gate_d  = GATE_DEFAULT;
      idx_d   = '0;
      cnt_d   = '0;
      chg_d   = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_DISABLED;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      gate_q  <= GATE_DEFAULT;
      chg_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      gate_q  <= gate_d;
      chg_q   <= chg_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ov_gate_state   = gate_q;
  assign ov_slot_index   = idx_q;
  assign o_slot_change   = chg_q;
  assign o_cycle_overrun = ovr_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_gate_ctrl_list_sequencer.sv
// Bench for gate_ctrl_list_sequencer: directed list scenarios plus randomized traffic,
// every cycle compared against a remaining-clocks model of the list schedule.
module tb_gate_ctrl_list_sequencer;
  import tsn_gcl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              cs;
  logic              en;
  logic [NUM_W-1:0]  num;
  logic [GATE_W-1:0] gate_out;
  logic [IDX_W-1:0]  idx_out;
  logic              chg_out;
  logic              ovr_out;
  gcl_state_e        dbg_state;

  gcl_cfg_if cfg_bus ();

  gate_ctrl_list_sequencer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cycle_start    (cs),
    .i_gcl_enable     (en),
    .iv_gcl_entry_num (num),
    .cfg              (cfg_bus),
    .ov_gate_state    (gate_out),
    .ov_slot_index    (idx_out),
    .o_slot_change    (chg_out),
    .o_cycle_overrun  (ovr_out),
    .o_dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [GATE_W-1:0] m_gate [GCL_DEPTH];
  int                m_intv [GCL_DEPTH];
  bit  m_armed, m_active, m_valid, idx_known;
  int  m_slot, m_left, m_last, nxt;
  logic [GATE_W-1:0] e_gate;
  int  e_idx;
  bit  e_chg, e_ovr;

  initial begin
    m_valid = 0;
    idx_known = 0;
  end

  // m_left = clocks the active entry still shows including the current one; 0 = holding last entry
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GCL_DEPTH; i++) begin
        m_gate[i] = '0;
        m_intv[i] = 0;
      end
      m_armed = 0; m_active = 0; m_left = 0; m_slot = 0; m_last = 0;
      e_gate = GATE_DEFAULT; e_idx = 0; e_chg = 0; e_ovr = 0;
      idx_known = 1; m_valid = 1;
    end else begin
      e_chg = 0; e_ovr = 0; nxt = -1;
      if (!en) begin
        m_armed = 0; m_active = 0; m_left = 0;
        e_gate = GATE_DEFAULT; idx_known = 0;
      end else if (!m_armed) begin
        m_armed = 1;
      end else if (cs) begin
        if (m_active && m_left > 0 && !(m_slot == m_last && m_left == 1)) e_ovr = 1;
        nxt = 0;
      end else if (m_active && m_left > 0) begin
        if (m_left == 1) begin
          if (m_slot < m_last) nxt = m_slot + 1;
          else m_left = 0;
        end else begin
          m_left--;
        end
      end
      if (nxt >= 0) begin
        m_slot = nxt;
        m_left = (m_intv[nxt] == 0) ? 1 : m_intv[nxt];
        m_last = (num == 0) ? 0 : ((int'(num) > GCL_DEPTH) ? GCL_DEPTH - 1 : int'(num) - 1);
        m_active = 1;
        e_gate = m_gate[nxt]; e_idx = nxt; e_chg = 1; idx_known = 1;
      end
      if (cfg_bus.i_gcl_wr) begin
        m_gate[cfg_bus.iv_gcl_waddr] = cfg_bus.iv_gcl_wdata[ENTRY_W-1:INTV_W];
        m_intv[cfg_bus.iv_gcl_waddr] = int'(cfg_bus.iv_gcl_wdata[INTV_W-1:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("gate", 32'(gate_out), 32'(e_gate));
      check("slot_change", 32'(chg_out), 32'(e_chg));
      check("overrun", 32'(ovr_out), 32'(e_ovr));
      if (idx_known) check("slot_index", 32'(idx_out), 32'(e_idx));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    cs = 1'b1;
    tick(1);
    cs = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input logic [GATE_W-1:0] g, input int iv);
    cfg_bus.i_gcl_wr     = 1'b1;
    cfg_bus.iv_gcl_waddr = IDX_W'(addr);
    cfg_bus.iv_gcl_wdata = {g, INTV_W'(iv)};
    tick(1);
    cfg_bus.i_gcl_wr     = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; cs = 1'b0; num = '0;
    cfg_bus.i_gcl_wr = 1'b0; cfg_bus.iv_gcl_waddr = '0; cfg_bus.iv_gcl_wdata = '0;
    tick(3);
    rst = 1'b0;
    check("t1_gate", 32'(gate_out), 32'hFF);
    check("t1_idx", 32'(idx_out), 32'h0);
    tick(4);
    check("t1_idle_gate", 32'(gate_out), 32'hFF);

    // T2: three-entry list
    cfg_write(0, 8'h01, 4);
    cfg_write(1, 8'h02, 2);
    cfg_write(2, 8'h80, 3);
    num = NUM_W'(3);
    en = 1'b1;
    tick(2);
    pulse();                                   // now at N+1
    check("t2_n1_gate", 32'(gate_out), 32'h01);
    check("t2_n1_chg", 32'(chg_out), 32'h1);
    tick(3);                                   // N+4
    check("t2_n4_gate", 32'(gate_out), 32'h01);
    tick(1);                                   // N+5
    check("t2_n5_gate", 32'(gate_out), 32'h02);
    check("t2_n5_chg", 32'(chg_out), 32'h1);
    tick(2);                                   // N+7
    check("t2_n7_gate", 32'(gate_out), 32'h80);
    check("t2_n7_idx", 32'(idx_out), 32'h2);
    tick(5);
    check("t2_hold_gate", 32'(gate_out), 32'h80);

    // T3: second start while entry 1 is active
    pulse();
    tick(4);
    pulse();
    check("t3_gate", 32'(gate_out), 32'h01);
    check("t3_overrun", 32'(ovr_out), 32'h1);

    // T4: start exactly at last-entry expiry
    tick(8);
    pulse();
    check("t4_no_overrun", 32'(ovr_out), 32'h0);
    check("t4_reload_gate", 32'(gate_out), 32'h01);
    tick(12);
    cfg_write(1, 8'h04, 0);
    pulse();
    tick(12);
    num = '0;
    pulse();
    tick(10);
    check("t4_num0_hold", 32'(gate_out), 32'h01);
    num = NUM_W'(3);

    // T5: rewrite the active entry
    pulse();
    cfg_write(0, 8'h0F, 5);
    check("t5_active_unchanged", 32'(gate_out), 32'h01);
    tick(12);
    pulse();
    check("t5_new_gate", 32'(gate_out), 32'h0F);
    tick(4);
    check("t5_new_last_clk", 32'(gate_out), 32'h0F);

    // T6: disable mid-list, ignored pulses, restart
    tick(2);
    en = 1'b0;
    tick(1);
    check("t6_disabled_gate", 32'(gate_out), 32'hFF);
    pulse();
    tick(2);
    en = 1'b1; cs = 1'b1;                      // start in the enable cycle is ignored
    tick(1);
    cs = 1'b0;
    check("t6_enable_cycle", 32'(gate_out), 32'hFF);
    tick(1);
    pulse();
    check("t6_restart_idx", 32'(idx_out), 32'h0);
    check("t6_restart_gate", 32'(gate_out), 32'h0F);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      cs = ($urandom_range(0, 11) == 0);
      cfg_bus.i_gcl_wr = ($urandom_range(0, 9) == 0);
      cfg_bus.iv_gcl_waddr = IDX_W'($urandom_range(0, GCL_DEPTH - 1));
      cfg_bus.iv_gcl_wdata = {GATE_W'($urandom), INTV_W'($urandom_range(0, 6))};
      if ($urandom_range(0, 39) == 0) num = NUM_W'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) en = ~en;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      rst = ($urandom_range(0, 799) == 0);
      tick(1);
    end
    rst = 1'b0; cs = 1'b0; cfg_bus.i_gcl_wr = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
